// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   mul_state_t : control FSM states
//   MUL_WIDTH   : default operand/result width
//   FLAG_*      : bit positions within the {N,Z,C,V} flag nibble
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    localparam int unsigned MUL_WIDTH = 32;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: partial product P, shifting multiplicand M, shifting
// multiplier Q and the iteration counter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : load operands (P <- acc or 0, M <- a, Q <- b, cnt <- 0)
//   step_i         : perform one shift-add iteration
//   accumulate_i   : select acc_i as the initial partial product
//   a_i, b_i, acc_i: operands
//   p_step_o       : partial product after the current iteration (combinational)
//   last_o         : current iteration is the final one
module mul_datapath
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             accumulate_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] p_step_o,
    output logic             last_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] p_step;

    assign p_step   = q_q[0] ? (p_q + m_q) : p_q;
    assign p_step_o = p_step;
    assign last_o   = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (load_i) begin
            p_d   = accumulate_i ? acc_i : '0;
            m_d   = a_i;
            q_d   = b_i;
            cnt_d = '0;
        end else if (step_i) begin
            p_d   = p_step;
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL/MLA unit with NZCV flag generation. Fixed latency of WIDTH
// RUN cycles; result/flags are registered and only change on completion.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : request an operation (honoured in IDLE or DONE only)
//   accumulate_i   : 1 = MLA (add acc_i), 0 = MUL
//   a_i, b_i, acc_i: multiplicand, multiplier, accumulate operand
//   flags_in_i     : current {N,Z,C,V}; C and V are captured at start
//   busy_o         : operation in progress (pipeline stall)
//   done_o         : one-cycle completion pulse
//   result_o       : (a*b + acc) mod 2^WIDTH
//   flags_out_o    : {result MSB, result==0, captured C, captured V}
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             accumulate_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [3:0]       flags_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_out_o
);

    mul_state_t       state_q, state_d;
    logic [1:0]       cv_q, cv_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             step;
    logic             last;
    logic             finish;
    logic [WIDTH-1:0] p_step;

    // N and Z are recomputed from the product; only C/V come from the input.
    logic unused_flags_in;
    assign unused_flags_in = ^flags_in_i[3:2];

    assign accept = start_i && (state_q == IDLE || state_q == DONE);
    assign step   = (state_q == RUN);
    assign finish = step && last;

    mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (accept),
        .step_i       (step),
        .accumulate_i (accumulate_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .acc_i        (acc_i),
        .p_step_o     (p_step),
        .last_o       (last)
    );

    always_comb begin
        state_d  = state_q;
        cv_d     = cv_q;
        result_d = result_q;
        flags_d  = flags_q;

        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cv_d = flags_in_i[1:0];
        end

        // Capture the final iteration's sum directly so outputs are valid in DONE.
        if (finish) begin
            result_d        = p_step;
            flags_d[FLAG_N] = p_step[WIDTH-1];
            flags_d[FLAG_Z] = (p_step == '0);
            flags_d[FLAG_C] = cv_q[1];
            flags_d[FLAG_V] = cv_q[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cv_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cv_q     <= cv_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign result_o    = result_q;
    assign flags_out_o = flags_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit (WIDTH=32): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_mul_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         accumulate;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic [3:0]   flags_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the registered outputs.
    logic [W-1:0] exp_res;
    logic [3:0]   exp_flg;

    mul_unit #(
        .WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .accumulate_i (accumulate),
        .a_i          (a),
        .b_i          (b),
        .acc_i        (acc),
        .flags_in_i   (flags_in),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .flags_out_o  (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                                input logic [W-1:0] rc, input logic racc);
        logic [63:0] full;
        full = 64'(ra) * 64'(rb) + (racc ? 64'(rc) : 64'd0);
        return full[W-1:0];
    endfunction

    function automatic logic [3:0] ref_flags(input logic [W-1:0] r, input logic [3:0] fl);
        return {r[W-1], (r == '0), fl[1], fl[0]};
    endfunction

    task automatic scramble();
        a          = $urandom;
        b          = $urandom;
        acc        = $urandom;
        flags_in   = 4'($urandom);
        accumulate = 1'($urandom);
    endtask

    // Called at #1 after a posedge with the DUT in IDLE or DONE. Returns at #1
    // after the posedge that begins the DONE cycle (or after the budget expires).
    task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic [W-1:0] oc, input logic oacc, input logic [3:0] ofl,
                         input int inject_at);
        logic [W-1:0] r;
        int           cyc;
        int           nbusy;
        logic         seen;
        r          = ref_result(oa, ob, oc, oacc);
        start      = 1'b1;
        a          = oa;
        b          = ob;
        acc        = oc;
        accumulate = oacc;
        flags_in   = ofl;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        cyc   = 1;
        nbusy = 0;
        seen  = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nbusy++;
                if (cyc == 5) begin
                    check({tag, "/held_result"}, 64'(result), 64'(exp_res));
                    check({tag, "/held_flags"}, 64'(flags_out), 64'(exp_flg));
                end
                if (cyc == inject_at) begin
                    start = 1'b1;
                    scramble();
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start   = 1'b0;
        exp_res = r;
        exp_flg = ref_flags(r, ofl);
        check({tag, "/done_cycle"}, 64'(cyc), 64'd33);
        check({tag, "/busy_cycles"}, 64'(nbusy), 64'd32);
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "/result"}, 64'(result), 64'(exp_res));
        check({tag, "/flags"}, 64'(flags_out), 64'(exp_flg));
    endtask

    // One cycle after DONE with no start: done drops, outputs hold.
    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "/idle_done"}, 64'(done), 64'd0);
        check({tag, "/idle_busy"}, 64'(busy), 64'd0);
        check({tag, "/idle_result"}, 64'(result), 64'(exp_res));
        check({tag, "/idle_flags"}, 64'(flags_out), 64'(exp_flg));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        accumulate = 1'b0;
        a          = '0;
        b          = '0;
        acc        = '0;
        flags_in   = '0;
        exp_res    = '0;
        exp_flg    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/result", 64'(result), 64'd0);
        check("reset/flags", 64'(flags_out), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic MUL.
        do_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 4'b0011, 0);
        check("mul7x6/value", 64'(result), 64'd42);
        check("mul7x6/flagval", 64'(flags_out), 64'h3);
        idle_check("mul7x6");

        // MLA wrapping to zero.
        do_op("mla_wrap", 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 4'b0000, 0);
        check("mla_wrap/flagval", 64'(flags_out), 64'h4);
        idle_check("mla_wrap");

        // Overflow to zero, then negative product.
        do_op("ovf_zero", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'b0000, 0);
        idle_check("ovf_zero");
        do_op("neg", 32'h4000_0000, 32'd2, 32'd0, 1'b0, 4'b0000, 0);
        check("neg/value", 64'(result), 64'h8000_0000);
        idle_check("neg");

        // Start ignored mid-RUN, then back-to-back from DONE.
        do_op("ignored", 32'd11, 32'd13, 32'd0, 1'b0, 4'b0001, 10);
        check("ignored/value", 64'(result), 64'd143);
        do_op("b2b", 32'd3, 32'd5, 32'd0, 1'b0, 4'b0010, 0);
        check("b2b/value", 64'(result), 64'd15);
        idle_check("b2b");

        // Zero operand still takes the full latency.
        do_op("zero", 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 4'b1110, 0);
        check("zero/flagval", 64'(flags_out), 64'h6);
        idle_check("zero");

        // Reset in cycle 10 of an operation.
        begin
            logic saw_done;
            start      = 1'b1;
            a          = 32'd9;
            b          = 32'd9;
            accumulate = 1'b0;
            flags_in   = 4'b0011;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset   = 1'b0;
            exp_res = '0;
            exp_flg = '0;
            check("rst_mid/busy", 64'(busy), 64'd0);
            check("rst_mid/done", 64'(done), 64'd0);
            check("rst_mid/result", 64'(result), 64'd0);
            check("rst_mid/flags", 64'(flags_out), 64'd0);
            saw_done = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done || busy) saw_done = 1'b1;
            end
            check("rst_mid/no_done", 64'(saw_done), 64'd0);
        end

        // Randomized operations, some back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb, rc;
            logic         racc;
            logic [3:0]   rfl;
            ra   = $urandom;
            rb   = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            rc   = $urandom;
            racc = 1'($urandom);
            rfl  = 4'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, rc, racc, rfl, (i % 3 == 0) ? 7 : 0);
            if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative shift-add multiplier (MUL/MLA) that sits beside the ALU in the execute stage and feeds the conditional-execution flag logic. It accepts one operation per start pulse and asserts `busy` so the hazard logic can stall the pipeline. It returns a WIDTH-bit product, optionally accumulated, plus an NZCV flag nibble in the same {N,Z,C,V} order the flag registers use. C and V pass through unchanged from the flags captured at start.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only in IDLE or DONE.
- `accumulate` in 1: 1 selects MLA (add `acc`), 0 selects MUL.
- `a` in WIDTH: multiplicand (Rm).
- `b` in WIDTH: multiplier (Rs).
- `acc` in WIDTH: accumulate operand (Rn); ignored when `accumulate`=0.
- `flags_in` in 4: current {N,Z,C,V}; bits [1:0] are captured at start.
- `busy` out 1: operation in progress; pipeline stall request.
- `done` out 1: one-cycle pulse when `result` and `flags_out` become valid.
- `result` out WIDTH: (a*b + (accumulate ? acc : 0)) mod 2^WIDTH.
- `flags_out` out 4: {result[WIDTH-1], result==0, C_captured, V_captured}.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE after exactly WIDTH iterations.
  - DONE → RUN when `start`=1; otherwise DONE → IDLE.
- On accept (IDLE/DONE with `start`), load the internal registers:
  - P ← accumulate ? acc : 0
  - M ← a
  - Q ← b
  - Cv ← flags_in[1:0]
  - cnt ← 0
- Each RUN cycle:
  - If Q[0], P ← P + M (mod 2^WIDTH).
  - M ← M << 1; Q ← Q >> 1; cnt ← cnt + 1.
  - cnt is $clog2(WIDTH+1) bits wide. Leave RUN when cnt reaches WIDTH-1 during that cycle.
- No early termination. Latency is fixed regardless of operand values.
- `result` and `flags_out` are registered outputs. They update only on the RUN → DONE transition and hold until the next completion or reset. New operands never disturb them during RUN.
- `start` during RUN is ignored, with no queueing.
- Operand inputs are sampled only on the accept cycle and may change afterwards.
- Unsigned and signed MUL give identical low WIDTH bits, so no sign handling is needed.

## Timing
- Start sampled at edge 0:
  - `busy`=1 in cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1, with `busy`=0.
  - `result` and `flags_out` are valid from cycle WIDTH+1.
- Back-to-back: `start` in the DONE cycle gives `busy`=1 in the next cycle. Throughput is one operation per WIDTH+1 cycles.
- `busy` and `done` are never high together. `done` lasts exactly one cycle per operation.
- Reset, including mid-RUN:
  - Next state is IDLE.
  - `busy`=0, `done`=0, `result`=0, `flags_out`=0.
  - P, M, Q, cnt and Cv are cleared. The aborted operation produces no `done`.
- Reset has priority over `start` in the same cycle.

## Structure
- Package `mul_pkg` holds:
  - the state enum `mul_state_t` {IDLE, RUN, DONE};
  - the constant `MUL_WIDTH` = 32;
  - the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, `mul_datapath`, holds the P/M/Q/cnt registers with load/step controls.
- The top level contains the FSM and the output registers.

## Test plan
All scenarios use WIDTH=32.
1. MUL: a=7, b=6, flags_in=4'b0011, start at edge 0 → `busy` in cycles 1..32, `done` in cycle 33, result=42, flags_out=4'b0011.
2. MLA wrap: a=32'hFFFF_FFFF, b=1, acc=1, accumulate=1, flags_in=0 → result=0, flags_out=4'b0100.
3. Overflow/negative: a=32'h0001_0000, b=32'h0001_0000 → result=0, Z=1. Then a=32'h4000_0000, b=2 → result=32'h8000_0000, flags_out[3:2]=2'b10.
4. Ignored start and back-to-back: assert `start` with new operands in cycle 10 of RUN → first result is unchanged. Then `start` in the DONE cycle with a=3, b=5 → `busy` next cycle, second `done` 33 cycles later with result=15.
5. Reset mid-op: start a=9, b=9, assert `reset` in cycle 10 → next cycle `busy`=0, `done`=0, result=0, flags_out=0, and no `done` ever appears for that operation.
6. Zero operand: a=0, b=32'hDEAD_BEEF, accumulate=0, flags_in=4'b1110 → result=0, flags_out=4'b0110, still 32 RUN cycles.
